// File: rtl/alu_operand_seq.sv
// alu_operand_seq: serialises instructions onto an external ALU, with an 8-entry register file
// ports: clk/rst clock and sync reset; instr_* instruction handshake and fields;
//        alu_x/alu_y/alu_op drive the ALU, alu_z is its result; result_* writeback strobe;
//        dbg_addr/dbg_data combinational register-file read.
module alu_operand_seq #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs,
  input  logic [REG_AW-1:0] instr_rt,
  input  logic              instr_imm_en,
  input  logic              instr_ld,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_z,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  output logic [REG_AW-1:0] result_rd,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_rf [2**REG_AW];
  logic [DATA_W-1:0] r_x, r_y, r_res;
  logic [3:0]        r_op;
  logic [REG_AW-1:0] r_rd;
  logic              w_acc;
  assign w_acc        = instr_valid & instr_ready;
  assign instr_ready  = (r_state == IDLE) & ~rst;
  // gating with rst suppresses the strobe in the cycle a reset aborts a WB
  assign result_valid = (r_state == WB) & ~rst;
  assign result_data  = r_res;
  assign result_rd    = r_rd;
  assign alu_x        = r_x;
  assign alu_y        = r_y;
  assign alu_op       = r_op;
  assign dbg_data     = r_rf[dbg_addr];
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_acc ? (instr_ld ? WB : EXEC) : IDLE) :
             r_state == EXEC ? WB : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf  <= '{default: '0};
      r_x   <= '0;
      r_y   <= '0;
      r_op  <= '0;
      r_res <= '0;
      r_rd  <= '0;
    end else begin
      if (w_acc && !instr_ld) begin
        r_x  <= r_rf[instr_rs];
        r_y  <= instr_imm_en ? instr_imm : r_rf[instr_rt];
        r_op <= instr_op;
      end
      if (w_acc) r_rd <= instr_rd;
      if (w_acc && instr_ld) r_res <= instr_imm;
      if (r_state == EXEC) r_res <= alu_z;
      if (r_state == WB) r_rf[r_rd] <= r_res;
    end
  end
endmodule

// File: tb/tb_alu_operand_seq.sv
// tb_alu_operand_seq: directed and randomised checks of alu_operand_seq against an architectural model
module tb_alu_operand_seq;
  logic        clk = 0;
  logic        rst, instr_valid, instr_ready, instr_imm_en, instr_ld, result_valid;
  logic [3:0]  instr_op, alu_op;
  logic [2:0]  instr_rd, instr_rs, instr_rt, result_rd, dbg_addr;
  logic [15:0] instr_imm, alu_x, alu_y, alu_z, result_data, dbg_data;
  int passed = 0, total = 0;
  logic [15:0] m [8];
  logic [15:0] px, py;
  logic [3:0]  pop;
  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, rs, rt;
    logic        ie, ld;
    logic [15:0] imm;
  } ins_t;
  ins_t sq [12];

  alu_operand_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
    .instr_imm_en(instr_imm_en), .instr_ld(instr_ld), .instr_imm(instr_imm),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_z(alu_z),
    .result_valid(result_valid), .result_data(result_data), .result_rd(result_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data));

  assign alu_z = alu_x + alu_y;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 8; a++) begin
      dbg_addr = 3'(a);
      #1 chk(tag, dbg_data, m[a]);
    end
  endtask

  task automatic drive(input ins_t t);
    instr_op = t.op; instr_rd = t.rd; instr_rs = t.rs; instr_rt = t.rt;
    instr_imm_en = t.ie; instr_ld = t.ld; instr_imm = t.imm;
  endtask

  task automatic do_instr(input ins_t t);
    logic [15:0] x, y, res;
    x   = m[t.rs];
    y   = t.ie ? t.imm : m[t.rt];
    res = t.ld ? t.imm : 16'(x + y);
    chk("ready_before", instr_ready, 1);
    drive(t);
    instr_valid = 1;
    @(posedge clk);
    #1 instr_valid = 0;
    @(negedge clk);
    if (!t.ld) begin
      px = x; py = y; pop = t.op;
      chk("exec_valid", result_valid, 0);
      chk("exec_ready", instr_ready, 0);
      chk("exec_x", alu_x, x);
      chk("exec_y", alu_y, y);
      chk("exec_op", alu_op, t.op);
      @(negedge clk);
    end
    chk("wb_valid", result_valid, 1);
    chk("wb_data", result_data, res);
    chk("wb_rd", result_rd, t.rd);
    chk("wb_ready", instr_ready, 0);
    chk("hold_x", alu_x, px);
    chk("hold_y", alu_y, py);
    chk("hold_op", alu_op, pop);
    sweep("dbg_old");
    m[t.rd] = res;
    @(negedge clk);
    chk("post_valid", result_valid, 0);
    chk("post_ready", instr_ready, 1);
    sweep("dbg_new");
  endtask

  function automatic ins_t mk(input logic [3:0] op, input logic [2:0] rd, rs, rt,
                              input logic ie, ld, input logic [15:0] imm);
    mk = '{op: op, rd: rd, rs: rs, rt: rt, ie: ie, ld: ld, imm: imm};
  endfunction

  function automatic ins_t rnd(input logic ldok);
    rnd = mk(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
             1'($urandom), ldok & ($urandom_range(0, 2) == 0), 16'($urandom));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int k, cnt, old, cyc;
    logic [15:0] pres;
    logic [2:0]  prd;
    rst = 1; instr_valid = 0; dbg_addr = 0;
    drive(mk(0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) m[i] = 0;
    px = 0; py = 0; pop = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_x", alu_x, 0);
    chk("rst_y", alu_y, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_data", result_data, 0);
    chk("rst_rd", result_rd, 0);
    sweep("rst_dbg");
    rst = 0;
    @(negedge clk);
    chk("rel_ready", instr_ready, 1);
    do_instr(mk(4'h2, 1, 0, 0, 0, 1, 16'h0003));
    do_instr(mk(4'h2, 2, 0, 0, 0, 1, 16'h0004));
    do_instr(mk(4'h1, 3, 1, 2, 0, 0, 16'h0000));
    chk("r3_sum", m[3], 16'h0007);
    do_instr(mk(4'h1, 3, 3, 0, 1, 0, 16'hFFFF));
    chk("r3_wrap", m[3], 16'h0006);
    do_instr(mk(4'h5, 1, 1, 1, 0, 0, 16'h0000));
    do_instr(mk(4'h6, 2, 3, 1, 1, 1, 16'hBEEF));
    for (int op = 0; op < 16; op++) begin
      ins_t t;
      t = rnd(0);
      t.op = 4'(op);
      do_instr(t);
    end
    for (int i = 0; i < 12; i++) sq[i] = rnd(1);
    k = 0; cnt = 0; cyc = 0;
    while ((k < 12 || cnt > 0) && cyc < 200) begin
      chk("str_ready", instr_ready, cnt == 0);
      chk("str_valid", result_valid, cnt == 1);
      if (cnt == 1) begin
        chk("str_data", result_data, pres);
        chk("str_rd", result_rd, prd);
        m[prd] = pres;
      end
      old = cnt;
      cnt = cnt > 0 ? cnt - 1 : 0;
      instr_valid = k < 12;
      if (k < 12) drive(sq[k]);
      if (old == 0 && k < 12) begin
        prd  = sq[k].rd;
        pres = sq[k].ld ? sq[k].imm :
               16'(m[sq[k].rs] + (sq[k].ie ? sq[k].imm : m[sq[k].rt]));
        if (!sq[k].ld) begin
          px = m[sq[k].rs]; py = sq[k].ie ? sq[k].imm : m[sq[k].rt]; pop = sq[k].op;
        end
        cnt = sq[k].ld ? 1 : 2;
        k++;
        if (k < 12) begin
          @(posedge clk);
          #1 drive(sq[k]);
        end
      end
      @(negedge clk);
      cyc++;
    end
    instr_valid = 0;
    chk("str_done", cyc < 200, 1);
    sweep("str_dbg");
    do_instr(mk(4'h0, 5, 0, 0, 0, 1, 16'h1234));
    drive(mk(4'h3, 5, 5, 5, 0, 0, 16'h0000));
    instr_valid = 1;
    @(posedge clk);
    #1 instr_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("abort_valid", result_valid, 0);
    chk("abort_ready", instr_ready, 0);
    chk("abort_x", alu_x, 0);
    chk("abort_y", alu_y, 0);
    chk("abort_op", alu_op, 0);
    chk("abort_data", result_data, 0);
    chk("abort_rd", result_rd, 0);
    for (int i = 0; i < 8; i++) m[i] = 0;
    px = 0; py = 0; pop = 0;
    sweep("abort_dbg");
    rst = 0;
    @(negedge clk);
    chk("abort_rel_ready", instr_ready, 1);
    chk("abort_rel_valid", result_valid, 0);
    do_instr(mk(4'h4, 6, 5, 5, 1, 0, 16'h00A5));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
